// File: rtl/ifetch_prefetch_buf_pkg.sv
// Shared Y86 fetch definitions: prefetch FSM state encoding, the width of the
// instruction window presented to decode, and the instruction-memory word size.
package ifetch_prefetch_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

  localparam int WIN_BYTES  = 10;  // longest Y86 instruction
  localparam int WORD_BYTES = 8;   // one memory read returns this many bytes

endpackage

// File: rtl/prefetch_byte_ring.sv
// Circular byte store for the prefetch buffer.
// Accepts up to one memory word per cycle and releases up to one instruction
// window per cycle. Pointers wrap modulo DEPTH, which must be a power of two.
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   flush                   empty the ring (takes priority over push/pop)
//   push_en/push_data/len   append push_len (0..8) low bytes of push_data at tail
//   pop_en/pop_len          retire pop_len bytes from head
//   count                   bytes currently held
//   peek_bytes              first WIN_BYTES bytes from head, zero past count
module prefetch_byte_ring
  import ifetch_prefetch_buf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push_en,
  input  logic [63:0]              push_data,
  input  logic [3:0]               push_len,
  input  logic                     pop_en,
  input  logic [3:0]               pop_len,
  output logic [$clog2(DEPTH):0]   count,
  output logic [8*WIN_BYTES-1:0]   peek_bytes
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    store [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] push_amt;
  logic [CW-1:0] pop_amt;

  always_comb begin
    push_amt = push_en ? CW'(push_len) : '0;
    pop_amt  = pop_en  ? CW'(pop_len)  : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(push_amt);
      head  <= head + AW'(pop_amt);
      count <= count + push_amt - pop_amt;
    end
  end

  // Storage carries no reset: bytes outside [head, head+count) are never shown.
  always_ff @(posedge clock) begin
    if (push_en && !flush) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (4'(i) < push_len) store[tail + AW'(i)] <= push_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    peek_bytes = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      if (count > CW'(i)) peek_bytes[8*i +: 8] = store[head + AW'(i)];
    end
  end

endmodule

// File: rtl/ifetch_prefetch_buf.sv
// Y86 instruction prefetch buffer: keeps a byte ring topped up from
// instruction memory one 8-byte word at a time and presents the next
// WIN_BYTES bytes to the fetch stage with zero latency.
// Ports:
//   clock, reset_n            clock and synchronous active-low reset
//   redirect, redirect_pc     flush and restart fetching at a byte address
//   mem_req, mem_addr         word read request (held stable until mem_ack)
//   mem_ack, mem_rdata, mem_err  response; mem_err marks the word invalid
//   win_bytes/valid/pc        instruction window and its byte address
//   consume, consume_len      bytes retired by the fetch stage this cycle
//   adr_err                   sticky memory-error flag, cleared by redirect
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no request; issue one when >= 8 bytes free
// ST_WAIT | mem_req high at req_addr, waiting for mem_ack
// ST_ERR  | memory error seen; fetching stopped until redirect
module ifetch_prefetch_buf
  import ifetch_prefetch_buf_pkg::*;
#(
  parameter int DEPTH_BYTES = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   redirect,
  input  logic [63:0]            redirect_pc,
  output logic                   mem_req,
  output logic [63:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [63:0]            mem_rdata,
  input  logic                   mem_err,
  output logic [8*WIN_BYTES-1:0] win_bytes,
  output logic [3:0]             win_valid,
  output logic [63:0]            win_pc,
  input  logic                   consume,
  input  logic [3:0]             consume_len,
  output logic                   adr_err
);

  localparam int CW = $clog2(DEPTH_BYTES) + 1;

  fetch_state_e  state, state_nxt;
  logic [63:0]   fetch_addr;
  logic [63:0]   req_addr;
  logic [2:0]    skip;
  logic          drop;
  logic [CW-1:0] count;
  logic          space_ok;
  logic          consume_ok;
  logic          flush;
  logic          push_en;
  logic          pop_en;
  logic [63:0]   push_data;
  logic [3:0]    push_len;

  assign space_ok  = count <= CW'(DEPTH_BYTES - WORD_BYTES);
  assign win_valid = (count > CW'(WIN_BYTES)) ? 4'(WIN_BYTES) : count[3:0];
  assign mem_req   = (state == ST_WAIT);
  assign mem_addr  = req_addr;

  // The first word after a redirect starts mid-word; shift off the skipped bytes.
  assign push_data = mem_rdata >> {skip, 3'b000};
  assign push_len  = 4'(WORD_BYTES) - {1'b0, skip};

  always_comb begin
    state_nxt  = state;
    push_en    = 1'b0;
    pop_en     = 1'b0;
    flush      = 1'b0;
    consume_ok = consume && (consume_len != 4'd0) && (consume_len <= win_valid);
    case (state)
      ST_IDLE: if (!redirect && !adr_err && space_ok) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack) begin
          if (redirect || drop) begin
            state_nxt = ST_IDLE;
          end else if (mem_err) begin
            state_nxt = ST_ERR;
          end else begin
            state_nxt = ST_IDLE;
            push_en   = 1'b1;
          end
        end
      end
      ST_ERR:  if (redirect) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (redirect) flush  = 1'b1;
    else          pop_en = consume_ok;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      fetch_addr <= '0;
      req_addr   <= '0;
      skip       <= '0;
      drop       <= 1'b0;
      adr_err    <= 1'b0;
      win_pc     <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        win_pc     <= redirect_pc;
        fetch_addr <= {redirect_pc[63:3], 3'b000};
        skip       <= redirect_pc[2:0];
        adr_err    <= 1'b0;
        // A request still in flight must have its response discarded.
        drop       <= (state == ST_WAIT) && !mem_ack;
      end else begin
        if (pop_en) win_pc <= win_pc + 64'(consume_len);
        if (state == ST_IDLE && state_nxt == ST_WAIT) req_addr <= fetch_addr;
        if (state == ST_WAIT && mem_ack) begin
          drop <= 1'b0;
          if (!drop && mem_err) adr_err <= 1'b1;
          if (push_en) begin
            fetch_addr <= fetch_addr + 64'd8;
            skip       <= '0;
          end
        end
      end
    end
  end

  prefetch_byte_ring #(.DEPTH(DEPTH_BYTES)) u_ring (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .push_en    (push_en),
    .push_data  (push_data),
    .push_len   (push_len),
    .pop_en     (pop_en),
    .pop_len    (consume_len),
    .count      (count),
    .peek_bytes (win_bytes)
  );

endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
module tb_ifetch_prefetch_buf;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  logic [79:0] win_bytes;
  logic [3:0]  win_valid;
  logic [63:0] win_pc;
  logic        consume;
  logic [3:0]  consume_len;
  logic        adr_err;

  int errors = 0;
  int checks = 0;

  // memory model controls
  int          resp_delay = 0;
  int          wait_cnt = 0;
  logic        fill_ff = 1'b0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;

  ifetch_prefetch_buf #(.DEPTH_BYTES(16)) dut (
    .clock(clock), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .win_bytes(win_bytes), .win_valid(win_valid), .win_pc(win_pc),
    .consume(consume), .consume_len(consume_len), .adr_err(adr_err)
  );

  always #5 clock = ~clock;

  // Memory content: the byte at address a is a[7:0].
  function automatic logic [63:0] word_at(input logic [63:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(a + 64'(i));
    return w;
  endfunction

  function automatic logic [79:0] exp_win(input logic [63:0] pc, input int v);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) if (i < v) r[8*i +: 8] = 8'(pc + 64'(i));
    return r;
  endfunction

  // Responder: acks resp_delay cycles after mem_req is first seen.
  always @(negedge clock) begin
    if (!mem_req) begin
      mem_ack = 1'b0; mem_err = 1'b0; wait_cnt = 0;
    end else if (wait_cnt >= resp_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = fill_ff ? 64'hFFFF_FFFF_FFFF_FFFF : word_at(mem_addr);
      mem_err   = err_en && (mem_addr == err_addr);
      wait_cnt  = 0;
    end else begin
      mem_ack = 1'b0; mem_err = 1'b0; wait_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; consume = 1'b0; consume_len = '0;
    cyc(); cyc();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0b want 0", mem_req); end
    checks++; if (win_valid !== 4'd0) begin errors++; $display("FAIL rst_win_valid: got %0d want 0", win_valid); end
    checks++; if (win_pc !== 64'd0) begin errors++; $display("FAIL rst_win_pc: got %h want 0", win_pc); end
    checks++; if (adr_err !== 1'b0) begin errors++; $display("FAIL rst_adr_err: got %0b want 0", adr_err); end
    checks++; if (win_bytes !== 80'd0) begin errors++; $display("FAIL rst_win_bytes: got %h want 0", win_bytes); end
    reset_n = 1'b1;
    cyc();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'd0) begin errors++; $display("FAIL first_req: got req=%0b addr=%h want req=1 addr=0", mem_req, mem_addr); end
  endtask

  task automatic test_fill();
    cyc();
    checks++; if (win_valid !== 4'd8) begin errors++; $display("FAIL fill_valid8: got %0d want 8", win_valid); end
    checks++; if (win_bytes !== exp_win(64'd0, 8)) begin errors++; $display("FAIL fill_bytes8: got %h want %h", win_bytes, exp_win(64'd0, 8)); end
    cyc();
    checks++; if (mem_addr !== 64'd8) begin errors++; $display("FAIL fill_addr8: got %h want 8", mem_addr); end
    cyc();
    checks++; if (win_valid !== 4'd10 || win_pc !== 64'd0) begin errors++; $display("FAIL fill_valid10: got valid=%0d pc=%h want 10/0", win_valid, win_pc); end
    checks++; if (win_bytes !== exp_win(64'd0, 10)) begin errors++; $display("FAIL fill_bytes10: got %h want %h", win_bytes, exp_win(64'd0, 10)); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_no_req: got %0b want 0", mem_req); end
  endtask

  task automatic test_consume_wrap();
    consume = 1'b1; consume_len = 4'd10;
    cyc();
    consume_len = 4'd2;
    checks++; if (win_pc !== 64'd10 || win_valid !== 4'd6) begin errors++; $display("FAIL cons10: got pc=%0d valid=%0d want 10/6", win_pc, win_valid); end
    checks++; if (win_bytes !== exp_win(64'd10, 6)) begin errors++; $display("FAIL cons10_bytes: got %h want %h", win_bytes, exp_win(64'd10, 6)); end
    cyc();
    consume = 1'b0;
    checks++; if (win_pc !== 64'd12 || win_valid !== 4'd4) begin errors++; $display("FAIL cons2: got pc=%0d valid=%0d want 12/4", win_pc, win_valid); end
    checks++; if (mem_addr !== 64'd16) begin errors++; $display("FAIL cons2_addr: got %h want 10", mem_addr); end
    cyc();
    checks++; if (win_valid !== 4'd10 || win_bytes !== exp_win(64'd12, 10)) begin errors++; $display("FAIL wrap_bytes: got valid=%0d bytes=%h want 10 %h", win_valid, win_bytes, exp_win(64'd12, 10)); end
    consume = 1'b1; consume_len = 4'd9;
    cyc();
    checks++; if (win_pc !== 64'd21 || win_bytes !== exp_win(64'd21, 3)) begin errors++; $display("FAIL cons9: got pc=%0d bytes=%h want 21 %h", win_pc, win_bytes, exp_win(64'd21, 3)); end
  endtask

  task automatic test_bad_consume_and_overlap();
    consume_len = 4'd5;
    cyc();
    checks++; if (win_pc !== 64'd21 || win_valid !== 4'd3) begin errors++; $display("FAIL bad_consume: got pc=%0d valid=%0d want 21/3", win_pc, win_valid); end
    consume_len = 4'd2;
    cyc();
    consume = 1'b0;
    checks++; if (win_pc !== 64'd23 || win_valid !== 4'd9) begin errors++; $display("FAIL push_pop: got pc=%0d valid=%0d want 23/9", win_pc, win_valid); end
    checks++; if (win_bytes !== exp_win(64'd23, 9)) begin errors++; $display("FAIL push_pop_bytes: got %h want %h", win_bytes, exp_win(64'd23, 9)); end
  endtask

  task automatic test_redirect_skip();
    redirect = 1'b1; redirect_pc = 64'h13;
    cyc();
    redirect = 1'b0;
    checks++; if (win_valid !== 4'd0 || win_pc !== 64'h13) begin errors++; $display("FAIL redir_flush: got valid=%0d pc=%h want 0/13", win_valid, win_pc); end
    cyc();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h10) begin errors++; $display("FAIL redir_addr: got req=%0b addr=%h want 1/10", mem_req, mem_addr); end
    cyc();
    checks++; if (win_valid !== 4'd5 || win_bytes !== exp_win(64'h13, 5)) begin errors++; $display("FAIL redir_skip: got valid=%0d bytes=%h want 5 %h", win_valid, win_bytes, exp_win(64'h13, 5)); end
    cyc();
    checks++; if (mem_addr !== 64'h18) begin errors++; $display("FAIL redir_next_addr: got %h want 18", mem_addr); end
    cyc();
    checks++; if (win_valid !== 4'd10 || win_bytes !== exp_win(64'h13, 10)) begin errors++; $display("FAIL redir_full: got valid=%0d bytes=%h want 10 %h", win_valid, win_bytes, exp_win(64'h13, 10)); end
  endtask

  task automatic test_redirect_drop();
    resp_delay = 2; fill_ff = 1'b1;
    redirect = 1'b1; redirect_pc = 64'h100;
    cyc();
    redirect = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 64'h20B;
    cyc();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h100) begin errors++; $display("FAIL drop_stable: got req=%0b addr=%h want 1/100", mem_req, mem_addr); end
    checks++; if (win_valid !== 4'd0 || win_pc !== 64'h20B) begin errors++; $display("FAIL drop_flush: got valid=%0d pc=%h want 0/20b", win_valid, win_pc); end
    cyc();
    cyc();
    checks++; if (win_valid !== 4'd0 || mem_req !== 1'b0 || adr_err !== 1'b0) begin errors++; $display("FAIL drop_discard: got valid=%0d req=%0b err=%0b want 0/0/0", win_valid, mem_req, adr_err); end
    resp_delay = 0; fill_ff = 1'b0;
    cyc();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h208) begin errors++; $display("FAIL drop_rereq: got req=%0b addr=%h want 1/208", mem_req, mem_addr); end
    cyc();
    checks++; if (win_valid !== 4'd5 || win_bytes !== exp_win(64'h20B, 5)) begin errors++; $display("FAIL drop_nostale: got valid=%0d bytes=%h want 5 %h", win_valid, win_bytes, exp_win(64'h20B, 5)); end
  endtask

  task automatic test_mem_error();
    err_en = 1'b1; err_addr = 64'h40;
    redirect = 1'b1; redirect_pc = 64'h3A;
    cyc();
    redirect = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h40) begin errors++; $display("FAIL err_req: got req=%0b addr=%h want 1/40", mem_req, mem_addr); end
    cyc();
    checks++; if (adr_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL err_flag: got err=%0b req=%0b want 1/0", adr_err, mem_req); end
    checks++; if (win_valid !== 4'd6 || win_bytes !== exp_win(64'h3A, 6)) begin errors++; $display("FAIL err_keep: got valid=%0d bytes=%h want 6 %h", win_valid, win_bytes, exp_win(64'h3A, 6)); end
    cyc();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL err_stopped: got req=%0b want 0", mem_req); end
    consume = 1'b1; consume_len = 4'd4;
    cyc();
    consume = 1'b0;
    checks++; if (win_pc !== 64'h3E || win_bytes !== exp_win(64'h3E, 2) || adr_err !== 1'b1) begin errors++; $display("FAIL err_consume: got pc=%h bytes=%h err=%0b want 3e %h 1", win_pc, win_bytes, adr_err, exp_win(64'h3E, 2)); end
    err_en = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h80;
    cyc();
    redirect = 1'b0;
    checks++; if (adr_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", adr_err); end
  endtask

  task automatic test_reset_mid_wait();
    cyc(); cyc(); cyc();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h88 || win_valid !== 4'd8) begin errors++; $display("FAIL pre_reset: got req=%0b addr=%h valid=%0d want 1/88/8", mem_req, mem_addr, win_valid); end
    reset_n = 1'b0;
    cyc();
    checks++; if (mem_req !== 1'b0 || mem_addr !== 64'd0 || win_valid !== 4'd0 || win_pc !== 64'd0 || adr_err !== 1'b0 || win_bytes !== 80'd0) begin errors++; $display("FAIL mid_wait_reset: got req=%0b addr=%h valid=%0d pc=%h want all 0", mem_req, mem_addr, win_valid, win_pc); end
    reset_n = 1'b1;
    cyc();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'd0) begin errors++; $display("FAIL post_reset_req: got req=%0b addr=%h want 1/0", mem_req, mem_addr); end
    cyc();
    checks++; if (win_valid !== 4'd8 || win_pc !== 64'd0 || win_bytes !== exp_win(64'd0, 8)) begin errors++; $display("FAIL post_reset_fill: got valid=%0d pc=%h bytes=%h", win_valid, win_pc, win_bytes); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_consume_wrap();
    test_bad_consume_and_overlap();
    test_redirect_skip();
    test_redirect_drop();
    test_mem_error();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
